// File: rtl/pipe_scan_pkg.sv
// Shared types and default constants for the pipe temperature scan controller.
package pipe_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        EVAL  = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_TH_DEF = 8'd150;
    localparam logic [7:0] SHUT_TH_DEF  = 8'd250;
    localparam int         TIMEOUT_DEF  = 16;

    // Round-robin successor of a channel index, wrapping at num_ch.
    function automatic int unsigned next_ch(input int unsigned ch, input int unsigned num_ch);
        return (ch >= num_ch - 1) ? 0 : ch + 1;
    endfunction

endpackage

// File: rtl/pipe_scan_if.sv
// Handshake between the scan controller (master) and the shared ADC (slave).
interface pipe_scan_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic            adc_start;
    logic [CH_W-1:0] adc_ch;
    logic            adc_done;
    logic [7:0]      adc_data;

    modport master (
        output adc_start,
        output adc_ch,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        input  adc_ch,
        output adc_done,
        output adc_data
    );

endinterface

// File: rtl/temp_threshold_cmp.sv
// Purely combinational classifier of one 8-bit temperature code against two thresholds.
module temp_threshold_cmp
    import pipe_scan_pkg::*;
#(
    parameter logic [7:0] ALARM_TH = ALARM_TH_DEF,
    parameter logic [7:0] SHUT_TH  = SHUT_TH_DEF
) (
    input  logic [7:0] code,
    output logic       hot,
    output logic       critical
);

    assign hot      = (code >= ALARM_TH);
    assign critical = (code >= SHUT_TH);

endmodule

// File: rtl/pipe_scan_ctrl.sv
// Round-robin scan of NUM_CH pipe temperature sensors over one shared ADC.
// Optional feature: define PIPE_SCAN_DEBOUNCE_EN to require two consecutive critical samples for shutdown.
module pipe_scan_ctrl
    import pipe_scan_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] ALARM_TH = ALARM_TH_DEF,
    parameter logic [7:0] SHUT_TH  = SHUT_TH_DEF,
    parameter int         TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr,
    pipe_scan_if.master       adc,
    output logic [NUM_CH-1:0] alarm,
    output logic [NUM_CH-1:0] shutdown,
    output logic              shutdown_any,
    output logic              adc_fault
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [CH_W-1:0]   ch_q;
    logic              start_q;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        data_q;

    logic              hot;
    logic              critical;
    logic              timeout_hit;
    logic              set_sh;
    logic              set_al;
    logic              clr_al;
    logic [NUM_CH-1:0] sh_nxt;
    logic [NUM_CH-1:0] al_nxt;

    assign adc.adc_start = start_q;
    assign adc.adc_ch    = ch_q;

    temp_threshold_cmp #(
        .ALARM_TH (ALARM_TH),
        .SHUT_TH  (SHUT_TH)
    ) u_cmp (
        .code     (data_q),
        .hot      (hot),
        .critical (critical)
    );

`ifdef PIPE_SCAN_DEBOUNCE_EN
    // One bit per channel: the previous sample of that channel was critical.
    logic [NUM_CH-1:0] hist;

    // NOTE: small per-channel flag arrays are reset like any other control state so the first visit is deterministic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
        end else if (state == EVAL) begin
            hist[ch_q] <= critical;
        end
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        set_sh      = 1'b0;
        set_al      = 1'b0;
        clr_al      = 1'b0;
        timeout_hit = (state == WAIT) && !adc.adc_done && (cnt == CNT_W'(TIMEOUT - 1));

        if (state == EVAL) begin
            if (critical) begin
`ifdef PIPE_SCAN_DEBOUNCE_EN
                if (hist[ch_q]) set_sh = 1'b1;
                else            set_al = 1'b1;
`else
                set_sh = 1'b1;
`endif
            end else if (hot) begin
                set_al = 1'b1;
            end else begin
                clr_al = 1'b1;
            end
        end

        // Clear first, then apply the set, so a same-cycle shutdown set survives clr.
        sh_nxt = clr ? '0 : shutdown;
        al_nxt = alarm;
        if (set_sh) sh_nxt[ch_q] = 1'b1;
        if (set_al) al_nxt[ch_q] = 1'b1;
        if (clr_al) al_nxt[ch_q] = 1'b0;
        al_nxt = al_nxt & ~sh_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ch_q         <= '0;
            start_q      <= 1'b0;
            cnt          <= '0;
            data_q       <= '0;
            alarm        <= '0;
            shutdown     <= '0;
            shutdown_any <= 1'b0;
            adc_fault    <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            alarm        <= al_nxt;
            shutdown     <= sh_nxt;
            shutdown_any <= |sh_nxt;
            adc_fault    <= (adc_fault & ~clr) | timeout_hit;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (adc.adc_done) begin
                        data_q <= adc.adc_data;
                        state  <= EVAL;
                    end else if (timeout_hit) begin
                        // Abandon this channel; a disabled scan parks in IDLE instead of retrying.
                        ch_q    <= CH_W'(next_ch(32'(ch_q), NUM_CH));
                        state   <= enable ? START : IDLE;
                        start_q <= enable;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    ch_q    <= CH_W'(next_ch(32'(ch_q), NUM_CH));
                    state   <= enable ? START : IDLE;
                    start_q <= enable;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipe_scan_ctrl.md
PIPE_SCAN_CTRL -- requirements
Module: pipe_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of pipe sensor channels sharing one ADC (2..8).
REQ-002 SHALL have parameter ALARM_TH, default 8'd150: alarm threshold, inclusive.
REQ-003 SHALL have parameter SHUT_TH, default 8'd250: shutdown threshold, inclusive; SHUT_TH > ALARM_TH.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles allowed before an ADC fault is raised.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  scanning runs while high.
REQ-009 clr  in  1  one-cycle pulse; clears sticky shutdown[] and adc_fault.
REQ-010 adc_start  out  1  one-cycle conversion request to the shared ADC.
REQ-011 adc_ch  out  $clog2(NUM_CH)  channel select; stable from adc_start until done or timeout.
REQ-012 adc_done  in  1  one-cycle conversion-complete strobe; adc_data is valid in the same cycle.
REQ-013 adc_data  in  8  unsigned temperature code.
REQ-014 alarm  out  NUM_CH  per-channel alarm, one bit per channel.
REQ-015 shutdown  out  NUM_CH  per-channel sticky shutdown, one bit per channel.
REQ-016 shutdown_any  out  1  OR of all shutdown bits.
REQ-017 adc_fault  out  1  sticky ADC timeout flag.

Function
REQ-018 The FSM SHALL have exactly four states, IDLE, START, WAIT and EVAL, with these transitions:
- IDLE->START when enable=1.
- START->WAIT unconditionally; adc_start=1 only in START.
- WAIT->EVAL when adc_done=1; adc_data is registered on that edge.
- WAIT->START after TIMEOUT cycles without adc_done; adc_fault is set and the channel advances.
- EVAL->START if enable=1, else EVAL->IDLE.
REQ-019 Classification of the captured sample in EVAL SHALL be: data>=SHUT_TH sets shutdown[ch] and clears alarm[ch]; ALARM_TH<=data<SHUT_TH sets alarm[ch]; data<ALARM_TH clears alarm[ch].
REQ-020 alarm[ch] SHALL be 0 whenever shutdown[ch]=1 (mutual exclusion per channel).
REQ-021 Outputs SHALL update on the clock edge that ends EVAL, i.e. one cycle after the edge on which adc_done was sampled.
REQ-022 Channel order SHALL be round-robin 0..NUM_CH-1, wrapping to 0; the channel advances on leaving EVAL and on a timeout.
REQ-023 adc_done SHALL be ignored outside WAIT.
REQ-024 When clr and a shutdown set for the same channel occur in the same cycle, the set SHALL win; clr still clears all other channels and adc_fault.
REQ-025 Deasserting enable mid-conversion SHALL let the current conversion finish, through EVAL or timeout, before the FSM enters IDLE.
REQ-026 The timeout counter SHALL clear on entry to WAIT and SHALL saturate; it SHALL not wrap.

Reset
REQ-027 While reset=0, the block SHALL hold state=IDLE, channel=0, adc_start=0, alarm=0, shutdown=0, shutdown_any=0, adc_fault=0 and counter=0.
REQ-028 Asserting reset mid-conversion SHALL abort the conversion immediately; the first adc_start after release SHALL be for channel 0.

Configuration
REQ-029 Macro PIPE_SCAN_DEBOUNCE_EN defined: shutdown[ch] SHALL set only after two consecutive EVALs of that channel with data>=SHUT_TH; the first such sample raises alarm[ch] instead.
REQ-030 Macro PIPE_SCAN_DEBOUNCE_EN undefined: shutdown[ch] SHALL set on a single sample with data>=SHUT_TH, and no per-channel history registers SHALL exist.

Structure
REQ-031 Package pipe_scan_pkg SHALL hold the state enum, the default threshold constants and the timeout default.
REQ-032 Sub-module temp_threshold_cmp SHALL be purely combinational: 8-bit code in, {hot, critical} out, with the thresholds as parameters.

Verification
REQ-033 After reset release with enable=1 and adc_data=100 on every channel: adc_ch sequence 0,1,2,3,0, and alarm=0, shutdown=0.
REQ-034 ch1 returns 200 -> alarm=4'b0010 one cycle after done; ch1 then returns 100 on its next visit -> alarm=4'b0000.
REQ-035 ch2 returns 255 -> shutdown=4'b0100 and shutdown_any=1; ch2 later returns 100 -> shutdown stays 4'b0100 until clr, after which it is 4'b0000.
REQ-036 adc_done withheld for 16 cycles on ch3 -> adc_fault=1, next adc_start carries adc_ch=0, and outputs for ch3 are unchanged.
REQ-037 clr pulsed in the same cycle as a shutdown set on ch0 -> shutdown[0]=1, adc_fault=0.
REQ-038 With PIPE_SCAN_DEBOUNCE_EN defined, ch0 returns 255 then 255 -> after the first sample alarm[0]=1, shutdown[0]=0; after the second shutdown[0]=1, alarm[0]=0.
